// File: rtl/wf_rr_select_pkg.sv
// -----------------------------------------------------------------------------
// wf_rr_select_pkg
// Shared definitions for the round-robin wavefront selector.
//   NUM_WF        : number of wavefront slots (2..64)
//   WF_ID_W       : width of a wavefront id (>= clog2(NUM_WF))
//   wf_sel_state_e: selector FSM encoding, IDLE=0 / HOLD=1
//   wf_inc()      : pointer increment with explicit wrap at NUM_WF-1
// -----------------------------------------------------------------------------
package wf_rr_select_pkg;

  localparam int NUM_WF  = 40;
  localparam int WF_ID_W = 6;

  typedef enum logic {
    WF_SEL_IDLE = 1'b0,
    WF_SEL_HOLD = 1'b1
  } wf_sel_state_e;

  // NUM_WF is not a power of two, so the wrap must be explicit rather than a
  // natural overflow of the WF_ID_W-bit counter.
  function automatic logic [WF_ID_W-1:0] wf_inc(input logic [WF_ID_W-1:0] id);
    return (id == WF_ID_W'(NUM_WF - 1)) ? '0 : id + WF_ID_W'(1);
  endfunction

endpackage

// File: rtl/wf_rr_select_find_next.sv
// -----------------------------------------------------------------------------
// wf_rr_find_next
// Combinational round-robin search: first set bit of req at or after start,
// wrapping through the slots below start.
// Implementation is a double priority encode: one lowest-set-bit search over
// the bits at/above start, one over the whole vector; the upper hit wins.
// Ports:
//   req   [NUM_WF-1:0]  in   candidate bits
//   start [WF_ID_W-1:0] in   first slot to consider (must be < NUM_WF)
//   found               out  at least one req bit set
//   idx   [WF_ID_W-1:0] out  winning slot (0 when found=0)
// -----------------------------------------------------------------------------
module wf_rr_find_next
  import wf_rr_select_pkg::*;
(
  input  logic [NUM_WF-1:0]  req,
  input  logic [WF_ID_W-1:0] start,
  output logic               found,
  output logic [WF_ID_W-1:0] idx
);

  logic [NUM_WF-1:0]  w_hi_mask;
  logic [NUM_WF-1:0]  w_hi_req;
  logic               w_hi_found;
  logic [WF_ID_W-1:0] w_hi_idx;
  logic [WF_ID_W-1:0] w_lo_idx;

  always_comb begin
    for (int i = 0; i < NUM_WF; i++) begin
      w_hi_mask[i] = (WF_ID_W'(i) >= start);
    end
  end

  assign w_hi_req   = req & w_hi_mask;
  assign w_hi_found = |w_hi_req;
  assign found      = |req;

  // Scan downwards so the lowest set bit is the last one written.
  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment; otherwise synthesis infers a latch.
  always_comb begin
    w_hi_idx = '0;
    w_lo_idx = '0;
    for (int i = NUM_WF - 1; i >= 0; i--) begin
      if (w_hi_req[i]) w_hi_idx = WF_ID_W'(i);
      if (req[i])      w_lo_idx = WF_ID_W'(i);
    end
  end

  // Nothing at/above start means the winner is the lowest bit below it.
  assign idx = w_hi_found ? w_hi_idx : w_lo_idx;

endmodule

// File: rtl/wf_rr_select.sv
// -----------------------------------------------------------------------------
// wf_rr_select
// Round-robin wavefront selector. Registers one winner out of NUM_WF ready
// bits and holds it under a valid/ack handshake; the id drives the select of
// the downstream per-wavefront info mux. A pending selection is squashed when
// its wavefront is flushed (an ack in the same cycle takes priority).
// Optional feature macro: WF_SEL_B2B_EN -- on ack, search again in the same
// cycle (excluding the acked slot) so consecutive grants have no bubble.
// Ports:
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-high reset
//   ready_bits   in   [NUM_WF-1:0] per-wavefront eligibility
//   sel_ack      in   consumer takes sel_wfid (ignored while sel_valid=0)
//   flush_valid  in   flush request for flush_wfid
//   flush_wfid   in   [WF_ID_W-1:0] wavefront being flushed
//   sel_valid    out  sel_wfid holds a valid selection
//   sel_wfid     out  [WF_ID_W-1:0] selected wavefront, always < NUM_WF
// -----------------------------------------------------------------------------
module wf_rr_select
  import wf_rr_select_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_WF-1:0]  ready_bits,
  input  logic               sel_ack,
  input  logic               flush_valid,
  input  logic [WF_ID_W-1:0] flush_wfid,
  output logic               sel_valid,
  output logic [WF_ID_W-1:0] sel_wfid
);

  wf_sel_state_e      r_state;
  wf_sel_state_e      w_state_nxt;
  logic [WF_ID_W-1:0] r_sel_wfid;
  logic [WF_ID_W-1:0] w_sel_wfid_nxt;
  logic [WF_ID_W-1:0] r_last_grant;
  logic [WF_ID_W-1:0] w_last_grant_nxt;

  logic [NUM_WF-1:0]  w_search_req;
  logic [WF_ID_W-1:0] w_search_start;
  logic               w_found;
  logic [WF_ID_W-1:0] w_found_idx;

  // One search instance serves both cases: in IDLE it searches after the
  // last grant; with back-to-back grants enabled, in HOLD it searches after
  // the current selection with that slot masked out.
`ifdef WF_SEL_B2B_EN
  always_comb begin
    if (r_state == WF_SEL_HOLD) begin
      w_search_start = wf_inc(r_sel_wfid);
      w_search_req   = ready_bits & ~(NUM_WF'(1) << r_sel_wfid);
    end else begin
      w_search_start = wf_inc(r_last_grant);
      w_search_req   = ready_bits;
    end
  end
`else
  assign w_search_start = wf_inc(r_last_grant);
  assign w_search_req   = ready_bits;
`endif

  wf_rr_find_next u_find_next (
    .req   (w_search_req),
    .start (w_search_start),
    .found (w_found),
    .idx   (w_found_idx)
  );

  always_comb begin
    w_state_nxt      = r_state;
    w_sel_wfid_nxt   = r_sel_wfid;
    w_last_grant_nxt = r_last_grant;
    case (r_state)
      WF_SEL_IDLE: begin
        if (w_found) begin
          w_sel_wfid_nxt = w_found_idx;
          w_state_nxt    = WF_SEL_HOLD;
        end
      end
      WF_SEL_HOLD: begin
        // Ack beats a same-cycle flush of the same id; the grant is recorded.
        if (sel_ack) begin
          w_last_grant_nxt = r_sel_wfid;
`ifdef WF_SEL_B2B_EN
          if (w_found) begin
            w_sel_wfid_nxt = w_found_idx;
          end else begin
            w_state_nxt = WF_SEL_IDLE;
          end
`else
          w_state_nxt = WF_SEL_IDLE;
`endif
        end else if (flush_valid && (flush_wfid == r_sel_wfid)) begin
          w_state_nxt = WF_SEL_IDLE;
        end
      end
      default: w_state_nxt = WF_SEL_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= WF_SEL_IDLE;
      r_sel_wfid   <= '0;
      r_last_grant <= WF_ID_W'(NUM_WF - 1);
    end else begin
      r_state      <= w_state_nxt;
      r_sel_wfid   <= w_sel_wfid_nxt;
      r_last_grant <= w_last_grant_nxt;
    end
  end

  assign sel_valid = (r_state == WF_SEL_HOLD);
  assign sel_wfid  = r_sel_wfid;

endmodule

// File: tb/tb_wf_rr_select.sv
// -----------------------------------------------------------------------------
// tb_wf_rr_select
// Directed bench for wf_rr_select. A behavioural round-robin model (integer
// pointer arithmetic with modulo search) is compared against the DUT on every
// falling edge; directed steps add hand-computed literal expectations.
// Honours WF_SEL_B2B_EN so the same bench covers both builds.
// -----------------------------------------------------------------------------
module tb_wf_rr_select;
  import wf_rr_select_pkg::*;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NUM_WF-1:0]  ready_bits = '0;
  logic               sel_ack = 1'b0;
  logic               flush_valid = 1'b0;
  logic [WF_ID_W-1:0] flush_wfid = '0;
  logic               sel_valid;
  logic [WF_ID_W-1:0] sel_wfid;

  int n_checks = 0;
  int n_errors = 0;
  bit checking = 1'b0;

`ifdef WF_SEL_B2B_EN
  localparam int EXP_BUBBLES = 0;
`else
  localparam int EXP_BUBBLES = 3;
`endif

  always #5 clk = ~clk;

  wf_rr_select dut (
    .clk         (clk),
    .rst         (rst),
    .ready_bits  (ready_bits),
    .sel_ack     (sel_ack),
    .flush_valid (flush_valid),
    .flush_wfid  (flush_wfid),
    .sel_valid   (sel_valid),
    .sel_wfid    (sel_wfid)
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic logic [NUM_WF-1:0] bitm(input int i);
    return NUM_WF'(1) << i;
  endfunction

  // First set bit strictly after 'from', wrapping, skipping 'excl'.
  function automatic int rr_search(input logic [NUM_WF-1:0] req, input int from, input int excl);
    for (int k = 1; k <= NUM_WF; k++) begin
      int idx;
      idx = (from + k) % NUM_WF;
      if (idx != excl && req[idx]) return idx;
    end
    return -1;
  endfunction

  // ---------------- behavioural model ----------------
  int m_valid = 0;
  int m_wfid  = 0;
  int m_last  = NUM_WF - 1;
  int m_pick_idle;
  int m_pick_b2b;

  always_comb begin
    m_pick_idle = rr_search(ready_bits, m_last, -1);
    m_pick_b2b  = rr_search(ready_bits, m_wfid, m_wfid);
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 0;
      m_wfid  <= 0;
      m_last  <= NUM_WF - 1;
    end else if (m_valid == 0) begin
      if (m_pick_idle >= 0) begin
        m_valid <= 1;
        m_wfid  <= m_pick_idle;
      end
    end else if (sel_ack) begin
      m_last <= m_wfid;
`ifdef WF_SEL_B2B_EN
      if (m_pick_b2b >= 0) m_wfid <= m_pick_b2b;
      else                 m_valid <= 0;
`else
      m_valid <= 0;
`endif
    end else if (flush_valid && int'(flush_wfid) == m_wfid) begin
      m_valid <= 0;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (!rst && checking) begin
      check("model sel_valid", 32'(sel_valid), 32'(m_valid));
      if (m_valid != 0) check("model sel_wfid", 32'(sel_wfid), 32'(m_wfid));
      if (sel_valid) check("sel_wfid range", 32'(sel_wfid < WF_ID_W'(NUM_WF)), 32'd1);
    end
  end

  // Called at a falling edge; waits (bounded) for sel_valid, then checks id.
  task automatic wait_grant(input string name, input int expected);
    int cyc;
    cyc = 0;
    while (!sel_valid && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    check({name, " valid"}, 32'(sel_valid), 32'd1);
    check({name, " id"}, 32'(sel_wfid), 32'(expected));
  endtask

  task automatic ack_now(input logic [NUM_WF-1:0] ready_after);
    sel_ack    = 1'b1;
    ready_bits = ready_after;
    @(negedge clk);
    sel_ack = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int got[$];
    int exp_order[4];
    int bubbles;
    int cyc;
    exp_order = '{3, 17, 39, 3};
    bubbles   = 0;
    cyc       = 0;

    // Reset values.
    repeat (3) @(negedge clk);
    check("reset sel_valid", 32'(sel_valid), 32'd0);
    check("reset sel_wfid", 32'(sel_wfid), 32'd0);
    rst      = 1'b0;
    checking = 1'b1;

    // No ready bits: nothing selected.
    repeat (5) begin
      @(negedge clk);
      check("idle no ready", 32'(sel_valid), 32'd0);
    end

    // One-cycle latency, first search starts at slot 0.
    ready_bits = bitm(0);
    @(negedge clk);
    check("first grant valid", 32'(sel_valid), 32'd1);
    check("first grant id", 32'(sel_wfid), 32'd0);
    ack_now('0);

    // Round-robin order over 3/17/39, acking every grant.
    ready_bits = bitm(3) | bitm(17) | bitm(39);
    while (got.size() < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (sel_valid) begin
        got.push_back(int'(sel_wfid));
        sel_ack = 1'b1;
        if (got.size() == 4) ready_bits = '0;
      end else begin
        sel_ack = 1'b0;
        if (got.size() > 0) bubbles++;
      end
    end
    @(negedge clk);
    sel_ack = 1'b0;
    check("rr grant count", 32'(got.size()), 32'd4);
    for (int i = 0; i < got.size() && i < 4; i++) check("rr order", 32'(got[i]), 32'(exp_order[i]));
    check("rr bubbles", 32'(bubbles), 32'(EXP_BUBBLES));

    // Wrap: last grant 39, then bits 0 and 39 -> 0 then 39.
    ready_bits = bitm(39);
    wait_grant("wrap setup", 39);
    ack_now('0);
    ready_bits = bitm(0) | bitm(39);
    wait_grant("wrap to 0", 0);
    ack_now(bitm(0) | bitm(39));
    wait_grant("wrap then 39", 39);
    ack_now('0);

    // Hold stability: selection ignores ready changes.
    ready_bits = bitm(17);
    wait_grant("hold setup", 17);
    ready_bits = bitm(5);
    repeat (4) begin
      @(negedge clk);
      check("hold valid", 32'(sel_valid), 32'd1);
      check("hold id", 32'(sel_wfid), 32'd17);
    end

    // Matching flush squashes; last grant stays 39 so search starts at 0.
    flush_valid = 1'b1;
    flush_wfid  = WF_ID_W'(17);
    ready_bits  = bitm(5) | bitm(20);
    @(negedge clk);
    flush_valid = 1'b0;
    check("flush drop", 32'(sel_valid), 32'd0);
    wait_grant("after flush", 5);
    ack_now('0);

    // Ack and matching flush together: ack wins, search resumes at 18.
    ready_bits = bitm(17);
    wait_grant("flush+ack setup", 17);
    sel_ack     = 1'b1;
    flush_valid = 1'b1;
    flush_wfid  = WF_ID_W'(17);
    ready_bits  = bitm(5) | bitm(20);
    @(negedge clk);
    sel_ack     = 1'b0;
    flush_valid = 1'b0;
    wait_grant("flush+ack next", 20);
    ack_now('0);

    // Non-matching flush has no effect.
    ready_bits = bitm(5);
    wait_grant("nomatch setup", 5);
    flush_valid = 1'b1;
    flush_wfid  = WF_ID_W'(17);
    repeat (3) begin
      @(negedge clk);
      check("nomatch valid", 32'(sel_valid), 32'd1);
      check("nomatch id", 32'(sel_wfid), 32'd5);
    end
    flush_valid = 1'b0;

    // Async reset between edges while in HOLD.
    #2 rst = 1'b1;
    #1;
    check("async reset valid", 32'(sel_valid), 32'd0);
    check("async reset id", 32'(sel_wfid), 32'd0);
    ready_bits = bitm(5) | bitm(30);
    @(negedge clk);
    rst = 1'b0;
    wait_grant("post reset", 5);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/wf_rr_select.md
Name: wf_rr_select

Overview:
- Round-robin wavefront selector; produces the 6-bit wavefront id that drives the select input of the 40x35b per-wavefront info mux downstream.
- Scans 40 per-wavefront ready bits and registers one winner.
- Holds the winner stable under a valid/ack handshake until the consumer takes it.
- Supports squashing a pending selection when its wavefront is flushed.

Parameters:
- NUM_WF, 40, number of wavefront slots; must be 2..64.
- WF_ID_W, 6, width of a wavefront id; must be ≥ clog2(NUM_WF).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- ready_bits  input  NUM_WF  bit i=1: wavefront i eligible for selection.
- sel_ack  input  1  consumer accepts the current sel_wfid; only meaningful while sel_valid=1.
- flush_valid  input  1  flush request for flush_wfid.
- flush_wfid  input  WF_ID_W  wavefront being flushed.
- sel_valid  output  1  sel_wfid holds a valid selection.
- sel_wfid  output  WF_ID_W  selected wavefront id; feeds the mux select.

Behaviour:
- Reset (async assert; release sampled on clk):
  - sel_valid=0, sel_wfid=0, last_grant=NUM_WF-1, so the first search starts at slot 0.
  - State=IDLE.
- State IDLE:
  - Combinational search over ready_bits, starting at (last_grant+1) mod NUM_WF and wrapping through last_grant; first set bit wins.
  - If a winner exists: register sel_wfid=winner, sel_valid=1, go to HOLD.
  - Otherwise stay in IDLE with sel_valid=0.
  - Latency: ready bit set in cycle N gives sel_valid=1 in cycle N+1.
- State HOLD:
  - sel_valid and sel_wfid stay stable regardless of ready_bits changes. A deasserting ready bit does not retract the selection.
  - sel_ack=1: last_grant<=sel_wfid, sel_valid<=0, go to IDLE. This leaves one bubble cycle unless WF_SEL_B2B_EN is defined.
  - flush_valid=1, flush_wfid==sel_wfid, sel_ack=0: sel_valid<=0, last_grant unchanged, go to IDLE.
  - sel_ack and a matching flush in the same cycle: the ack wins and the grant is recorded. The flush is the consumer's responsibility.
  - Flush for a non-matching id: no effect.
- Arithmetic:
  - Wrap on last_grant+1 is explicit: NUM_WF-1 goes to 0. Pointer arithmetic is not a power-of-2 modulo.
  - sel_wfid is always < NUM_WF. Values 40–63 are never produced.
- sel_ack while sel_valid=0: ignored.
- State encoding: 1-bit, IDLE=0 / HOLD=1. No illegal states.

Optional Feature:
- Macro: WF_SEL_B2B_EN.
- Defined: back-to-back grants with no bubble.
  - On sel_ack in HOLD, the search runs in the same cycle, starting at (sel_wfid+1) mod NUM_WF, with bit sel_wfid masked out of ready_bits.
  - If a winner exists: sel_wfid<=winner, sel_valid stays 1, state stays HOLD, last_grant<=old sel_wfid.
  - If no winner: behaves as the base design.
  - The flush rule is unchanged.
- Undefined: the base behaviour above, with one bubble after every ack.

Decomposition:
- Shared package (global definitions):
  - NUM_WF.
  - WF_ID_W.
  - State encodings WF_SEL_IDLE / WF_SEL_HOLD.
- One combinational sub-module, wf_rr_find_next.
  - Inputs: req[NUM_WF-1:0] and start[WF_ID_W-1:0].
  - Outputs: found and idx.
  - Implementation: rotate-mask double-priority encode.
  - Reused for the base search and the B2B search.

Test Plan:
- Reset, then ready_bits=0 for 5 cycles → sel_valid stays 0. Set ready_bits bit 0 → sel_valid=1 and sel_wfid=0 next cycle.
- ready_bits = bits 3, 17, 39 held high; ack every selection → grant order 3, 17, 39, 3. Base build: one cycle with sel_valid=0 between grants. B2B build: none.
- Wrap: last grant 39, ready_bits = bits 0 and 39 → next sel_wfid=0. Then, after ack, 39.
- Hold stability: sel_wfid=17 with sel_valid=1; drop ready bit 17 and raise bit 5, no ack for 4 cycles → sel_wfid stays 17.
- Flush: sel_wfid=17 held; flush_valid=1 with flush_wfid=17 → sel_valid=0 next cycle, and the next grant search starts after the previous last_grant. Same cycle with sel_ack=1 → grant recorded, next search starts at 18. flush_wfid=5 → no effect.
- Async reset mid-HOLD: assert rst between edges → sel_valid drops immediately. After release, the first grant is from slot 0.
